// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the MEM/WB exception controller: excepttype codes,
// CP0 register numbers, Status/Cause bit positions and the default exception vector.
package exc_ctrl_pkg;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    localparam logic [31:0] EXCT_NONE = 32'h0;
    localparam logic [31:0] EXCT_INT  = 32'h1;
    localparam logic [31:0] EXCT_ADEL = 32'h4;
    localparam logic [31:0] EXCT_ADES = 32'h5;
    localparam logic [31:0] EXCT_SYS  = 32'h8;
    localparam logic [31:0] EXCT_BP   = 32'h9;
    localparam logic [31:0] EXCT_RI   = 32'hA;
    localparam logic [31:0] EXCT_OV   = 32'hC;
    localparam logic [31:0] EXCT_TRAP = 32'hD;
    localparam logic [31:0] EXCT_ERET = 32'hE;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int IM_LO      = 8;
    localparam int IM_HI      = 15;
    localparam int IP_LO      = 8;
    localparam int IP_HI      = 15;
    localparam int IP_SW_HI   = 9;

    // Bit positions in mem_exc_i; ascending index is also descending priority.
    localparam int EXC_ADEL_IF = 0;
    localparam int EXC_RI      = 1;
    localparam int EXC_SYS     = 2;
    localparam int EXC_BP      = 3;
    localparam int EXC_TRAP    = 4;
    localparam int EXC_OV      = 5;
    localparam int EXC_ADEL_D  = 6;
    localparam int EXC_ADES    = 7;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GUARD = 1'b1
    } state_e;

    function automatic logic int_pending(input logic [31:0] status, input logic [31:0] cause);
        return status[STATUS_IE] & ~status[STATUS_EXL]
             & (|(cause[IP_HI:IP_LO] & status[IM_HI:IM_LO]));
    endfunction

endpackage

// File: rtl/exc_ctrl_prio_enc.sv
// Combinational priority encoder: interrupt/exception flags/ERET -> excepttype code
// plus the BadVAddr source for address-error exceptions.
module exc_prio_enc
    import exc_ctrl_pkg::*;
(
    input  logic        int_req_i,
    input  logic [7:0]  exc_i,
    input  logic        eret_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] daddr_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] bad_addr_o
);

    always_comb begin
        excepttype_o = EXCT_NONE;
        bad_addr_o   = 32'h0;
        if (int_req_i) begin
            excepttype_o = EXCT_INT;
        end else if (exc_i[EXC_ADEL_IF]) begin
            excepttype_o = EXCT_ADEL;
            bad_addr_o   = pc_i;
        end else if (exc_i[EXC_RI]) begin
            excepttype_o = EXCT_RI;
        end else if (exc_i[EXC_SYS]) begin
            excepttype_o = EXCT_SYS;
        end else if (exc_i[EXC_BP]) begin
            excepttype_o = EXCT_BP;
        end else if (exc_i[EXC_TRAP]) begin
            excepttype_o = EXCT_TRAP;
        end else if (exc_i[EXC_OV]) begin
            excepttype_o = EXCT_OV;
        end else if (exc_i[EXC_ADEL_D]) begin
            excepttype_o = EXCT_ADEL;
            bad_addr_o   = daddr_i;
        end else if (exc_i[EXC_ADES]) begin
            excepttype_o = EXCT_ADES;
            bad_addr_o   = daddr_i;
        end else if (eret_i) begin
            excepttype_o = EXCT_ERET;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception detect/prioritise/commit unit at MEM/WB with a post-commit guard window.
// Optional macro EXC_CP0_FWD_EN forwards a same-cycle WB MTC0 into Status/Cause/EPC.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
    parameter int          GUARD_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_ds_i,
    input  logic [7:0]  mem_exc_i,
    input  logic        mem_eret_i,
    input  logic [31:0] mem_daddr_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] exc_pc_o,
    output logic        exc_in_ds_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        busy_o
);

    localparam logic [1:0] GUARD_INIT = 2'(GUARD_CYCLES);

    state_e      state_q;
    logic [1:0]  guard_cnt_q;
    logic [31:0] excepttype_q, exc_pc_q, bad_addr_q, new_pc_q;
    logic        exc_in_ds_q, flush_q, busy_q;

    logic [31:0] status_eff, cause_eff, epc_eff;
    logic        int_req, fire;
    logic [31:0] excepttype_d, bad_addr_d, new_pc_d;

`ifdef EXC_CP0_FWD_EN
    // Only the software interrupt bits of Cause are writable by MTC0.
    always_comb begin
        status_eff = cp0_status_i;
        cause_eff  = cp0_cause_i;
        epc_eff    = cp0_epc_i;
        if (wb_cp0_we_i) begin
            case (wb_cp0_waddr_i)
                CP0_STATUS: status_eff = wb_cp0_data_i;
                CP0_CAUSE:  cause_eff[IP_SW_HI:IP_LO] = wb_cp0_data_i[IP_SW_HI:IP_LO];
                CP0_EPC:    epc_eff = wb_cp0_data_i;
                default:    ;
            endcase
        end
    end
`else
    assign status_eff = cp0_status_i;
    assign cause_eff  = cp0_cause_i;
    assign epc_eff    = cp0_epc_i;
`endif

    logic unused_ok;
    assign unused_ok = ^{wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i, status_eff, cause_eff};

    assign int_req = int_pending(status_eff, cause_eff);
    assign fire    = ~stall_i & mem_valid_i & (int_req | (|mem_exc_i) | mem_eret_i);

    exc_prio_enc u_prio_enc (
        .int_req_i    (int_req),
        .exc_i        (mem_exc_i),
        .eret_i       (mem_eret_i),
        .pc_i         (mem_pc_i),
        .daddr_i      (mem_daddr_i),
        .excepttype_o (excepttype_d),
        .bad_addr_o   (bad_addr_d)
    );

    assign new_pc_d = (excepttype_d == EXCT_ERET) ? epc_eff : EXC_VECTOR;

    // excepttype_o/flush_o pulse for one cycle; the remaining outputs hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            guard_cnt_q  <= 2'd0;
            excepttype_q <= EXCT_NONE;
            exc_pc_q     <= 32'h0;
            exc_in_ds_q  <= 1'b0;
            bad_addr_q   <= 32'h0;
            flush_q      <= 1'b0;
            new_pc_q     <= 32'h0;
            busy_q       <= 1'b0;
        end else begin
            excepttype_q <= EXCT_NONE;
            flush_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (fire) begin
                        excepttype_q <= excepttype_d;
                        exc_pc_q     <= mem_pc_i;
                        exc_in_ds_q  <= mem_in_ds_i;
                        bad_addr_q   <= bad_addr_d;
                        new_pc_q     <= new_pc_d;
                        flush_q      <= 1'b1;
                        busy_q       <= 1'b1;
                        guard_cnt_q  <= GUARD_INIT;
                        state_q      <= S_GUARD;
                    end
                end
                S_GUARD: begin
                    if (guard_cnt_q <= 2'd1) begin
                        guard_cnt_q <= 2'd0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        guard_cnt_q <= guard_cnt_q - 2'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign excepttype_o = excepttype_q;
    assign exc_pc_o     = exc_pc_q;
    assign exc_in_ds_o  = exc_in_ds_q;
    assign bad_addr_o   = bad_addr_q;
    assign flush_o      = flush_q;
    assign new_pc_o     = new_pc_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of commit/guard behaviour.
module tb_exc_ctrl;

  localparam int          G   = 1;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, mem_valid_i, mem_in_ds_i, mem_eret_i;
  logic [31:0] mem_pc_i, mem_daddr_i, cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic [7:0]  mem_exc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic [31:0] excepttype_o, exc_pc_o, bad_addr_o, new_pc_o;
  logic        exc_in_ds_o, flush_o, busy_o;

  always #5 clk = ~clk;

  exc_ctrl #(.EXC_VECTOR(VEC), .GUARD_CYCLES(G)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .mem_valid_i    (mem_valid_i),
    .mem_pc_i       (mem_pc_i),
    .mem_in_ds_i    (mem_in_ds_i),
    .mem_exc_i      (mem_exc_i),
    .mem_eret_i     (mem_eret_i),
    .mem_daddr_i    (mem_daddr_i),
    .cp0_status_i   (cp0_status_i),
    .cp0_cause_i    (cp0_cause_i),
    .cp0_epc_i      (cp0_epc_i),
    .wb_cp0_we_i    (wb_cp0_we_i),
    .wb_cp0_waddr_i (wb_cp0_waddr_i),
    .wb_cp0_data_i  (wb_cp0_data_i),
    .excepttype_o   (excepttype_o),
    .exc_pc_o       (exc_pc_o),
    .exc_in_ds_o    (exc_in_ds_o),
    .bad_addr_o     (bad_addr_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .busy_o         (busy_o)
  );

  // {type, pc, ds, bad_addr, flush, new_pc, busy}
  logic [130:0] obs;
  assign obs = {excepttype_o, exc_pc_o, exc_in_ds_o, bad_addr_o, flush_o, new_pc_o, busy_o};

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  logic [31:0] m_type, m_pc, m_bad, m_newpc;
  logic        m_ds, m_flush, m_busy;
  int          m_guard;

  function automatic logic [130:0] pack(input logic [31:0] t, input logic [31:0] pc, input logic ds,
                                        input logic [31:0] bad, input logic fl, input logic [31:0] npc,
                                        input logic busy);
    return {t, pc, ds, bad, fl, npc, busy};
  endfunction

  task automatic drive_idle();
    rst = 1'b0; stall_i = 1'b0; mem_valid_i = 1'b0; mem_in_ds_i = 1'b0; mem_eret_i = 1'b0;
    mem_pc_i = 32'h0; mem_daddr_i = 32'h0; mem_exc_i = 8'h0;
    cp0_status_i = 32'h0; cp0_cause_i = 32'h0; cp0_epc_i = 32'h0;
    wb_cp0_we_i = 1'b0; wb_cp0_waddr_i = 5'd0; wb_cp0_data_i = 32'h0;
  endtask

  // One clock edge of the reference: what the outputs should show after it.
  task automatic model_edge();
    logic [31:0] st, ca, ep;
    int codes[8];
    logic intr, fire;
    codes = '{4, 10, 8, 9, 13, 12, 4, 5};
    if (rst) begin
      m_type = 0; m_pc = 0; m_ds = 0; m_bad = 0; m_flush = 0; m_newpc = 0; m_guard = 0;
    end else begin
      m_type = 0; m_flush = 0;
      if (m_guard > 0) begin
        m_guard = m_guard - 1;
      end else begin
        st = cp0_status_i; ca = cp0_cause_i; ep = cp0_epc_i;
`ifdef EXC_CP0_FWD_EN
        if (wb_cp0_we_i) begin
          if (wb_cp0_waddr_i == 5'd12) st = wb_cp0_data_i;
          if (wb_cp0_waddr_i == 5'd13) ca[9:8] = wb_cp0_data_i[9:8];
          if (wb_cp0_waddr_i == 5'd14) ep = wb_cp0_data_i;
        end
`endif
        intr = st[0] && !st[1] && ((st[15:8] & ca[15:8]) != 8'h0);
        fire = !stall_i && mem_valid_i && (intr || mem_exc_i != 8'h0 || mem_eret_i);
        if (fire) begin
          m_bad = 0;
          if (intr) m_type = 1;
          else if (mem_exc_i != 8'h0) begin
            for (int i = 7; i >= 0; i--) begin
              if (mem_exc_i[i]) begin
                m_type = codes[i];
                m_bad  = (i == 0) ? mem_pc_i : (i >= 6) ? mem_daddr_i : 32'h0;
              end
            end
          end else m_type = 32'hE;
          m_pc = mem_pc_i; m_ds = mem_in_ds_i; m_flush = 1;
          m_newpc = (m_type == 32'hE) ? ep : VEC;
          m_guard = G;
        end
      end
    end
    m_busy = (m_guard > 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    if (obs !== 131'h0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", obs); end
    n_checks++;
    rst = 1'b0;
  endtask

  task automatic test_syscall();
    logic [130:0] exp;
    mem_valid_i = 1; mem_pc_i = 32'h8000_0100; mem_in_ds_i = 0; mem_exc_i = 8'h04;
    @(negedge clk);
    exp = pack(32'h8, 32'h8000_0100, 0, 0, 1, VEC, 1);
    if (obs !== exp) begin n_fail++; $display("FAIL syscall_commit: got %h want %h", obs, exp); end
    n_checks++;
    drive_idle();
    @(negedge clk);
    exp = pack(32'h0, 32'h8000_0100, 0, 0, 0, VEC, 0);
    if (obs !== exp) begin n_fail++; $display("FAIL syscall_after: got %h want %h", obs, exp); end
    n_checks++;
  endtask

  task automatic test_fetch_prio();
    logic [130:0] exp;
    mem_valid_i = 1; mem_pc_i = 32'h8000_0202; mem_in_ds_i = 1; mem_exc_i = 8'h81;
    mem_daddr_i = 32'h1234_5678;
    @(negedge clk);
    exp = pack(32'h4, 32'h8000_0202, 1, 32'h8000_0202, 1, VEC, 1);
    if (obs !== exp) begin n_fail++; $display("FAIL fetch_prio: got %h want %h", obs, exp); end
    n_checks++;
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_interrupt();
    logic [130:0] exp;
    cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400; mem_pc_i = 32'h8000_0300;
    repeat (2) @(negedge clk);
    exp = pack(32'h0, 32'h8000_0202, 1, 32'h8000_0202, 0, VEC, 0);
    if (obs !== exp) begin n_fail++; $display("FAIL int_bubble_wait: got %h want %h", obs, exp); end
    n_checks++;
    mem_valid_i = 1;
    @(negedge clk);
    exp = pack(32'h1, 32'h8000_0300, 0, 0, 1, VEC, 1);
    if (obs !== exp) begin n_fail++; $display("FAIL int_commit: got %h want %h", obs, exp); end
    n_checks++;
    cp0_status_i = 32'h0000_0403;
    repeat (2) @(negedge clk);
    exp = pack(32'h0, 32'h8000_0300, 0, 0, 0, VEC, 0);
    if (obs !== exp) begin n_fail++; $display("FAIL int_exl_masked: got %h want %h", obs, exp); end
    n_checks++;
    drive_idle();
  endtask

  task automatic test_eret_fwd();
    logic [130:0] exp;
    logic [31:0]  target;
`ifdef EXC_CP0_FWD_EN
    target = 32'h8000_0080;
`else
    target = 32'h8000_0040;
`endif
    mem_valid_i = 1; mem_eret_i = 1; mem_pc_i = 32'h8000_0400; cp0_epc_i = 32'h8000_0040;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h8000_0080;
    @(negedge clk);
    exp = pack(32'hE, 32'h8000_0400, 0, 0, 1, target, 1);
    if (obs !== exp) begin n_fail++; $display("FAIL eret_target: got %h want %h", obs, exp); end
    n_checks++;
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [130:0] exp;
    mem_valid_i = 1; mem_pc_i = 32'h8000_0500; mem_exc_i = 8'h04;
    @(negedge clk);
    exp = pack(32'h8, 32'h8000_0500, 0, 0, 1, VEC, 1);
    if (obs !== exp) begin n_fail++; $display("FAIL b2b_first: got %h want %h", obs, exp); end
    n_checks++;
    mem_pc_i = 32'h8000_0504; mem_exc_i = 8'h02;
    @(negedge clk);
    exp = pack(32'h0, 32'h8000_0500, 0, 0, 0, VEC, 0);
    if (obs !== exp) begin n_fail++; $display("FAIL b2b_guard_suppress: got %h want %h", obs, exp); end
    n_checks++;
    @(negedge clk);
    exp = pack(32'hA, 32'h8000_0504, 0, 0, 1, VEC, 1);
    if (obs !== exp) begin n_fail++; $display("FAIL b2b_ri_commit: got %h want %h", obs, exp); end
    n_checks++;
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_stall_and_reset();
    logic [130:0] exp;
    stall_i = 1; mem_valid_i = 1; mem_pc_i = 32'h8000_0600; mem_exc_i = 8'h04;
    exp = pack(32'h0, 32'h8000_0504, 0, 0, 0, VEC, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (obs !== exp) begin n_fail++; $display("FAIL stall_hold[%0d]: got %h want %h", i, obs, exp); end
      n_checks++;
    end
    stall_i = 0;
    @(negedge clk);
    exp = pack(32'h8, 32'h8000_0600, 0, 0, 1, VEC, 1);
    if (obs !== exp) begin n_fail++; $display("FAIL stall_release: got %h want %h", obs, exp); end
    n_checks++;
    drive_idle();
    rst = 1;
    @(negedge clk);
    if (obs !== 131'h0) begin n_fail++; $display("FAIL reset_in_guard: got %h want 0", obs); end
    n_checks++;
    rst = 0;
  endtask

  task automatic test_random();
    logic [130:0] exp;
    rst = 1;
    @(posedge clk); model_edge();
    @(negedge clk);
    for (int c = 0; c < 600; c++) begin
      rst          = ($urandom_range(0, 59) == 0);
      stall_i      = ($urandom_range(0, 3) == 0);
      mem_valid_i  = ($urandom_range(0, 4) != 0);
      mem_pc_i     = $urandom;
      mem_in_ds_i  = 1'($urandom_range(0, 1));
      mem_exc_i    = ($urandom_range(0, 2) == 0) ?
                     (8'(1 << $urandom_range(0, 7)) | (($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h0)) : 8'h0;
      mem_eret_i   = ($urandom_range(0, 4) == 0);
      mem_daddr_i  = $urandom;
      cp0_status_i = {16'h0, 8'($urandom), 6'h0, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1))};
      cp0_cause_i  = {16'h0, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0, 8'h0};
      cp0_epc_i    = $urandom;
      wb_cp0_we_i  = ($urandom_range(0, 2) == 0);
      wb_cp0_waddr_i = 5'($urandom_range(11, 15));
      wb_cp0_data_i  = $urandom;
      @(posedge clk); model_edge();
      @(negedge clk);
      exp = pack(m_type, m_pc, m_ds, m_bad, m_flush, m_newpc, m_busy);
      if (obs !== exp) begin n_fail++; $display("FAIL random[%0d]: got %h want %h", c, obs, exp); end
      n_checks++;
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    @(negedge clk);
    test_reset();
    test_syscall();
    test_fetch_prio();
    test_interrupt();
    test_eret_fwd();
    test_back_to_back();
    test_stall_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
